// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter serialising CPU (port 0) and video/DMA (port 1) accesses onto the SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module sdram_arbiter #(
  parameter int TIMEOUT_W = 10
) (
  input  logic        CLOCK_100_del_3ns,
  input  logic        rst,
  input  logic [23:0] p0_addr,
  input  logic [23:0] p1_addr,
  input  logic        p0_rd,
  input  logic        p1_rd,
  input  logic        p0_wr,
  input  logic        p1_wr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p0_err,
  output logic        p1_err,
  output logic [23:0] mem_address,
  output logic        mem_req_read,
  output logic        mem_req_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_data_valid,
  input  logic        mem_write_complete,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d, op_q, op_d, done_q;
  logic [23:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 req0, req1, sel, launch, fin;
  assign req0   = p0_rd | p0_wr;
  assign req1   = p1_rd | p1_wr;
  assign launch = state_q == IDLE && (req0 | req1);
  assign fin    = state_q == WAIT && (done_q || wd_q == WD_FIRE);
`ifdef SDRAM_ARB_RR_EN
  logic ptr_q;
  assign sel = (req0 & req1) ? ptr_q : req1;
  always_ff @(posedge CLOCK_100_del_3ns) ptr_q <= rst ? 1'b0 : fin ? ~gnt_q : ptr_q;
`else
  assign sel = ~req0;
`endif
  always_ff @(posedge CLOCK_100_del_3ns) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      op_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      done_q   <= op_q ? mem_data_valid : mem_write_complete;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      wd_q     <= wd_d;
    end
  end
  // RELEASE holds until the registered completion flag drops so a lingering level never completes the next access
  always_comb begin
    state_d = state_q == IDLE  ? (launch ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (fin ? RELEASE : WAIT) :
                                 (done_q ? RELEASE : IDLE);
  end
  always_comb begin
    gnt_d    = launch ? sel : gnt_q;
    op_d     = launch ? (sel ? p1_rd : p0_rd) : op_q;
    addr_d   = launch ? (sel ? p1_addr : p0_addr) : addr_q;
    wdata_d  = launch ? (sel ? p1_wdata : p0_wdata) : wdata_q;
    wd_d     = state_q == WAIT ? wd_q + WD_ONE : '0;
    ack0_d   = fin & ~gnt_q;
    ack1_d   = fin & gnt_q;
    err0_d   = fin & ~done_q & ~gnt_q;
    err1_d   = fin & ~done_q & gnt_q;
    rdata0_d = (fin & done_q & op_q & ~gnt_q) ? mem_data_out : rdata0_q;
    rdata1_d = (fin & done_q & op_q & gnt_q) ? mem_data_out : rdata1_q;
    mem_req_read  = state_q == ISSUE && op_q;
    mem_req_write = state_q == ISSUE && !op_q;
    busy          = state_q != IDLE;
  end
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign p0_ack      = ack0_q;
  assign p1_ack      = ack1_q;
  assign p0_err      = err0_q;
  assign p1_err      = err1_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench with a cycle-indexed transaction model and a behavioural SDRAM controller.
module tb_sdram_arbiter;
  localparam int TW = 4;
  localparam int MAXC = 5000;
  logic        clk = 1'b0, rst;
  logic [23:0] p0_addr, p1_addr, mem_address;
  logic        p0_rd, p1_rd, p0_wr, p1_wr, p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_data_in, mem_data_out;
  logic        mem_req_read, mem_req_write, mem_data_valid, mem_write_complete, busy;
  int n_cmp = 0, n_bad = 0, cyc = 0, nreq = 0, last_req = 0, last_ack = 0;
  int c_lat, c_hold;
  bit c_never;
  logic [31:0] c_data;
  bit v_h[0:MAXC], w_h[0:MAXC];
  int order[$];

  sdram_arbiter #(.TIMEOUT_W(TW)) dut (
    .CLOCK_100_del_3ns(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_rd(p0_rd), .p1_rd(p1_rd),
    .p0_wr(p0_wr), .p1_wr(p1_wr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_ack(p0_ack), .p1_ack(p1_ack),
    .p0_err(p0_err), .p1_err(p1_err), .mem_address(mem_address),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .mem_write_complete(mem_write_complete),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_ack(input bit p);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = p ? p1_ack : p0_ack;
    end
    if (!seen) chk(p ? "ack1_wait" : "ack0_wait", 32'd0, 32'd1);
  endtask

  // Controller: completion level rises c_lat cycles after a request pulse and stays high c_hold cycles
  initial begin : ctrl
    int cnt, hcnt;
    bit rd_op;
    cnt = 0; hcnt = 0; rd_op = 0;
    mem_data_valid = 0; mem_write_complete = 0; mem_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cnt = 0; hcnt = 0; mem_data_valid = 0; mem_write_complete = 0;
      end else begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) begin mem_data_valid = 0; mem_write_complete = 0; end
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            if (rd_op) mem_data_valid = 1; else mem_write_complete = 1;
            hcnt = c_hold;
          end
        end
        if (mem_req_read | mem_req_write) begin
          rd_op = mem_req_read;
          cnt = c_never ? 0 : c_lat;
          mem_data_out = c_data;
        end
      end
    end
  end

  // Model: one transaction at a time, described by its grant edge g_at and ack edge a_at
  initial begin : sb
    bit mb, mrd, mg, mto, mptr, r0, r1, ea0, ea1, lv;
    int g_at, a_at;
    logic [23:0] maddr;
    logic [31:0] mwd, mr0, mr1;
    mb = 0; mrd = 0; mg = 0; mto = 0; mptr = 0; g_at = -10; a_at = -1;
    maddr = '0; mwd = '0; mr0 = '0; mr1 = '0;
    forever begin
      @(posedge clk);
      cyc++;
      v_h[cyc] = mem_data_valid;
      w_h[cyc] = mem_write_complete;
      ea0 = 0; ea1 = 0; mto = 0;
      r0 = p0_rd | p0_wr;
      r1 = p1_rd | p1_wr;
      lv = mrd ? v_h[cyc-1] : w_h[cyc-1];
      if (rst) begin
        mb = 0; mptr = 0; maddr = '0; mwd = '0; mr0 = '0; mr1 = '0; g_at = -10; a_at = -1;
      end else if (!mb) begin
        if (r0 | r1) begin
`ifdef SDRAM_ARB_RR_EN
          mg = (r0 && r1) ? mptr : r1;
`else
          mg = r0 ? 1'b0 : 1'b1;
`endif
          mb = 1; g_at = cyc; a_at = -1;
          mrd   = mg ? p1_rd : p0_rd;
          maddr = mg ? p1_addr : p0_addr;
          mwd   = mg ? p1_wdata : p0_wdata;
        end
      end else if (a_at < 0) begin
        if (cyc >= g_at + 2 && (lv || cyc == g_at + 2**TW)) begin
          a_at = cyc; mto = !lv; ea0 = !mg; ea1 = mg; mptr = !mg;
          if (lv && mrd && !mg) mr0 = mem_data_out;
          if (lv && mrd && mg) mr1 = mem_data_out;
        end
      end else if (!lv) mb = 0;
      @(negedge clk);
      if (mem_req_read | mem_req_write) begin nreq++; last_req = cyc; end
      if (p0_ack | p1_ack) last_ack = cyc;
      chk("req_read", mem_req_read, mb && g_at == cyc && mrd);
      chk("req_write", mem_req_write, mb && g_at == cyc && !mrd);
      chk("busy", busy, mb);
      chk("address", mem_address, maddr);
      chk("data_in", mem_data_in, mwd);
      chk("p0_ack", p0_ack, ea0);
      chk("p1_ack", p1_ack, ea1);
      chk("p0_err", p0_err, ea0 && mto);
      chk("p1_err", p1_err, ea1 && mto);
      chk("p0_rdata", p0_rdata, mr0);
      chk("p1_rdata", p1_rdata, mr1);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0, ack_c, gap;
    int exp_ord[4];
    rst = 1; p0_addr = '0; p1_addr = '0; p0_rd = 0; p1_rd = 0; p0_wr = 0; p1_wr = 0;
    p0_wdata = '0; p1_wdata = '0; c_lat = 2; c_hold = 1; c_never = 0; c_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_address", mem_address, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    rst = 0;
    // single read
    c_data = 32'hDEADBEEF; p0_addr = 24'h000123; p0_rd = 1; n0 = nreq;
    wait_ack(0);
    p0_rd = 0; #1;
    chk("rd_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_address", mem_address, 24'h000123);
    chk("rd_err", p0_err, 0);
    chk("rd_one_pulse", nreq - n0, 1);
    chk("rd_latency", last_ack - last_req, 4);
    // single write
    p1_addr = 24'h7FFFFF; p1_wdata = 32'h5A5A1234; p1_wr = 1;
    wait_ack(1);
    p1_wr = 0; #1;
    chk("wr_data_in", mem_data_in, 32'h5A5A1234);
    chk("wr_address", mem_address, 24'h7FFFFF);
    chk("wr_p1_rdata", p1_rdata, 0);
    // both ports read back-to-back
    c_data = 32'hCAFE0001; p0_addr = 24'h000010; p1_addr = 24'h000020;
    fork
      for (int k = 0; k < 2; k++) begin @(negedge clk); p0_rd = 1; wait_ack(0); order.push_back(0); p0_rd = 0; end
      for (int j = 0; j < 2; j++) begin @(negedge clk); p1_rd = 1; wait_ack(1); order.push_back(1); p1_rd = 0; end
    join
`ifdef SDRAM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 1, 1};
`endif
    chk("order_len", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("grant_order", order[i], exp_ord[i]);
    // stuck completion flag
    c_hold = 8; c_data = 32'h13572468;
    @(negedge clk); p0_rd = 1; p1_rd = 1;
    wait_ack(0);
    ack_c = cyc; p0_rd = 0; gap = -1;
    for (int i = 0; i < 40 && gap < 0; i++) begin
      @(negedge clk);
      if (mem_req_read | mem_req_write) gap = cyc - ack_c;
    end
    chk("stuck_gap", gap, 9);
    wait_ack(1);
    p1_rd = 0;
    chk("stuck_p1_rdata", p1_rdata, 32'h13572468);
    c_hold = 1;
    // watchdog
    c_never = 1; c_data = 32'h0000FFFF; p0_addr = 24'h000321; p0_rd = 1;
    wait_ack(0);
    p0_rd = 0; #1;
    chk("wd_err", p0_err, 1);
    chk("wd_rdata_kept", p0_rdata, 32'h13572468);
    chk("wd_delay", last_ack - last_req, 16);
    c_never = 0;
    // reset in WAIT
    c_lat = 20; @(negedge clk); p0_rd = 1; gap = -1;
    for (int i = 0; i < 20 && gap < 0; i++) begin
      @(negedge clk);
      if (mem_req_read) gap = 0;
    end
    chk("rst_mid_issue", gap, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", p0_ack, 0);
    chk("rst_mid_address", mem_address, 0);
    chk("rst_mid_rdata", p0_rdata, 0);
    p0_rd = 0; rst = 0; c_lat = 2;
    // recovery
    c_data = 32'h89ABCDEF; p1_addr = 24'h000456; p1_rd = 1;
    wait_ack(1);
    p1_rd = 0; #1;
    chk("recover_rdata", p1_rdata, 32'h89ABCDEF);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
